// File: rtl/frame_ram_writer.sv
// Frame RAM write side: buffers a valid/ready pixel stream and writes it to RAM addresses 0..FRAME_PIXELS-1.
// Optional FRAME_WRITER_CLEAR_EN adds a clear input that fills the frame with CLEAR_VALUE.
module frame_ram_writer #(
   parameter int                DATA_W       = 32,
   parameter int                ADDR_W       = 16,
   parameter int                FRAME_PIXELS = 65536,
   parameter int                FIFO_DEPTH   = 4,
   parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
`ifdef FRAME_WRITER_CLEAR_EN
   input  logic              clear,
`endif
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] ram_wraddress,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   output logic              busy,
   output logic              frame_done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
`ifdef FRAME_WRITER_CLEAR_EN
      S_CLEAR = 2'd3,
`endif
      S_DONE  = 2'd2
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    accept_cnt_q, write_cnt_q;
   logic [PTR_W:0]      wr_ptr_q, rd_ptr_q;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0]   ram_wraddress_q;
   logic [DATA_W-1:0]   ram_data_q;
   logic                ram_wren_q;
   logic                fifo_empty, fifo_full, push, pop;

   // Extra pointer bit distinguishes full from empty when the index bits match.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign in_ready   = (state_q == S_FILL) && !fifo_full && (accept_cnt_q < FRAME_CNT);
   assign push       = in_valid && in_ready;
   assign pop        = (state_q == S_FILL) && !fifo_empty && (write_cnt_q != FRAME_CNT);

   assign ram_wraddress = ram_wraddress_q;
   assign ram_data      = ram_data_q;
   assign ram_wren      = ram_wren_q;
   assign busy          = (state_q != S_IDLE);
   assign frame_done    = (state_q == S_DONE);

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= in_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= S_IDLE;
         accept_cnt_q    <= '0;
         write_cnt_q     <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         ram_wraddress_q <= '0;
         ram_data_q      <= '0;
         ram_wren_q      <= 1'b0;
      end else begin
         ram_wren_q <= 1'b0;
         if (push) begin
            wr_ptr_q     <= wr_ptr_q + PTR_ONE;
            accept_cnt_q <= accept_cnt_q + CNT_ONE;
         end
         case (state_q)
            S_IDLE: begin
`ifdef FRAME_WRITER_CLEAR_EN
               if (clear) begin
                  state_q      <= S_CLEAR;
                  accept_cnt_q <= '0;
                  write_cnt_q  <= '0;
               end else
`endif
               if (start) begin
                  state_q      <= S_FILL;
                  accept_cnt_q <= '0;
                  write_cnt_q  <= '0;
               end
            end
            S_FILL: begin
               if (write_cnt_q == FRAME_CNT) begin
                  state_q <= S_DONE;
               end else if (pop) begin
                  rd_ptr_q        <= rd_ptr_q + PTR_ONE;
                  ram_wren_q      <= 1'b1;
                  ram_wraddress_q <= write_cnt_q[ADDR_W-1:0];
                  ram_data_q      <= mem_q[rd_ptr_q[PTR_W-1:0]];
                  write_cnt_q     <= write_cnt_q + CNT_ONE;
               end
            end
`ifdef FRAME_WRITER_CLEAR_EN
            S_CLEAR: begin
               if (write_cnt_q == FRAME_CNT) begin
                  state_q <= S_DONE;
               end else begin
                  ram_wren_q      <= 1'b1;
                  ram_wraddress_q <= write_cnt_q[ADDR_W-1:0];
                  ram_data_q      <= CLEAR_VALUE;
                  write_cnt_q     <= write_cnt_q + CNT_ONE;
               end
            end
`endif
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_ram_writer.sv
// Directed bench for frame_ram_writer with a 16-word frame; a negedge monitor logs every RAM write.
module tb_frame_ram_writer;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int FP = 16;

   logic          clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, ram_wren, busy, frame_done;
   logic [AW-1:0] ram_wraddress;
   logic [DW-1:0] ram_data;
`ifdef FRAME_WRITER_CLEAR_EN
   logic          clear = 1'b0;
`endif

   int checks = 0, failures = 0;

   frame_ram_writer #(.DATA_W(DW), .ADDR_W(AW), .FRAME_PIXELS(FP), .FIFO_DEPTH(4),
                      .CLEAR_VALUE(32'hDEAD)) dut (
      .clk(clk), .reset(reset), .start(start),
`ifdef FRAME_WRITER_CLEAR_EN
      .clear(clear),
`endif
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .ram_wraddress(ram_wraddress), .ram_data(ram_data), .ram_wren(ram_wren),
      .busy(busy), .frame_done(frame_done));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [AW-1:0] wa_q[$];
   logic [DW-1:0] wd_q[$];
   int            wc_q[$];
   int            done_cnt = 0, done_cyc = -1;
   always @(negedge clk) begin
      if (ram_wren) begin
         wa_q.push_back(ram_wraddress);
         wd_q.push_back(ram_data);
         wc_q.push_back(cyc);
      end
      if (frame_done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic start_pulse;
      start = 1'b1; tick; start = 1'b0;
   endtask

   // Offers base+k for pixel k until FP are accepted; optionally re-pulses start at pixel start_at.
   task automatic stream(input logic [DW-1:0] base, input bit rnd, input int start_at,
                         output int acc, output int first_acc_cyc);
      int guard;
      acc = 0; guard = 0; first_acc_cyc = -1;
      while (acc < FP && guard < 400) begin
         in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = base + DW'(acc);
         start    = (start_at >= 0) && (acc == start_at);
         if (in_valid && in_ready) begin
            if (acc == 0) first_acc_cyc = cyc;
            acc++;
         end
         tick;
         guard++;
      end
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, output bit ok);
      int guard;
      guard = 0;
      while (done_cnt == d0 && guard < 60) begin tick; guard++; end
      ok = (done_cnt != d0);
      repeat (4) tick;
   endtask

   task automatic check_frame(input string nm, input int w0, input logic [DW-1:0] base);
      checks++;
      if (wa_q.size() - w0 !== FP) begin
         failures++;
         $display("FAIL %s_count got=%0d exp=%0d", nm, wa_q.size() - w0, FP);
      end
      for (int i = 0; i < FP && w0 + i < wa_q.size(); i++) begin
         checks++;
         if (wa_q[w0+i] !== AW'(i) || wd_q[w0+i] !== base + DW'(i)) begin
            failures++;
            $display("FAIL %s_write%0d got addr=%0d data=%h exp addr=%0d data=%h",
                     nm, i, wa_q[w0+i], wd_q[w0+i], i, base + DW'(i));
         end
      end
   endtask

   task automatic test_reset;
      int w0;
      reset = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
      repeat (3) tick;
      checks++;
      if ({in_ready, ram_wren, busy, frame_done} !== 4'b0000 || ram_wraddress !== '0 || ram_data !== '0) begin
         failures++;
         $display("FAIL reset_outputs got rdy=%b wren=%b busy=%b done=%b addr=%h data=%h exp all 0",
                  in_ready, ram_wren, busy, frame_done, ram_wraddress, ram_data);
      end
      w0 = wa_q.size();
      reset = 1'b1; start = 1'b0;
      repeat (5) tick;
      checks++;
      if (wa_q.size() !== w0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got writes=%0d busy=%b rdy=%b exp 0/0/0", wa_q.size() - w0, busy, in_ready);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_full_frame;
      int w0, d0, acc, fa;
      bit ok;
      w0 = wa_q.size(); d0 = done_cnt;
      start_pulse;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL full_busy got=%b exp=1", busy); end
      stream(32'h100, 1'b0, -1, acc, fa);
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready_after_last got=%b exp=0", in_ready); end
      in_valid = 1'b0;
      wait_done(d0, ok);
      checks++;
      if (!ok || done_cnt - d0 !== 1) begin
         failures++; $display("FAIL full_done_pulses got=%0d exp=1", done_cnt - d0);
      end
      check_frame("full", w0, 32'h100);
      if (wa_q.size() - w0 == FP) begin
         checks++;
         if (wc_q[w0] !== fa + 2) begin
            failures++; $display("FAIL full_latency got=%0d exp=2", wc_q[w0] - fa);
         end
         checks++;
         if (wc_q[w0+FP-1] - wc_q[w0] !== FP - 1) begin
            failures++; $display("FAIL full_throughput got span=%0d exp=%0d", wc_q[w0+FP-1] - wc_q[w0], FP - 1);
         end
         checks++;
         if (done_cyc !== wc_q[w0+FP-1] + 1) begin
            failures++; $display("FAIL full_done_timing got=%0d exp=%0d", done_cyc, wc_q[w0+FP-1] + 1);
         end
      end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL full_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_backpressure;
      int w0, d0, acc, fa;
      bit ok;
      w0 = wa_q.size(); d0 = done_cnt;
      start_pulse;
      stream(32'hCAFE_0000, 1'b1, -1, acc, fa);
      in_valid = 1'b1; in_data = 32'hBAD0_BAD0;
      repeat (3) tick;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_after_last got=%b exp=0", in_ready); end
      in_valid = 1'b0;
      wait_done(d0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_done got=0 exp=1"); end
      check_frame("bp", w0, 32'hCAFE_0000);
   endtask

   task automatic test_start_mid_frame;
      int w0, d0, acc, fa;
      bit ok;
      w0 = wa_q.size(); d0 = done_cnt;
      start_pulse;
      stream(32'h4000, 1'b0, 5, acc, fa);
      in_valid = 1'b0;
      wait_done(d0, ok);
      checks++;
      if (!ok || done_cnt - d0 !== 1) begin
         failures++; $display("FAIL midstart_done got=%0d exp=1", done_cnt - d0);
      end
      check_frame("midstart", w0, 32'h4000);
   endtask

   task automatic test_reset_mid_frame;
      int w0, d0, acc, fa, guard;
      bit ok;
      w0 = wa_q.size(); d0 = done_cnt; acc = 0; guard = 0;
      start_pulse;
      while (wa_q.size() - w0 < 7 && guard < 100) begin
         in_valid = 1'b1; in_data = 32'h700 + DW'(acc);
         if (in_ready) acc++;
         tick; guard++;
      end
      reset = 1'b0;
      #1;
      checks++;
      if (ram_wren !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         failures++; $display("FAIL abort_async got wren=%b busy=%b rdy=%b exp 0/0/0", ram_wren, busy, in_ready);
      end
      in_valid = 1'b0;
      repeat (2) tick;
      reset = 1'b1;
      repeat (3) tick;
      checks++;
      if (wa_q.size() - w0 !== 7 || done_cnt !== d0) begin
         failures++; $display("FAIL abort_partial got writes=%0d done=%0d exp writes=7 done=0",
                              wa_q.size() - w0, done_cnt - d0);
      end
      w0 = wa_q.size();
      start_pulse;
      stream(32'h500, 1'b0, -1, acc, fa);
      in_valid = 1'b0;
      wait_done(d0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL restart_done got=0 exp=1"); end
      check_frame("restart", w0, 32'h500);
   endtask

`ifdef FRAME_WRITER_CLEAR_EN
   task automatic test_clear;
      int w0, d0;
      bit ok, bad_rdy;
      w0 = wa_q.size(); d0 = done_cnt; bad_rdy = 1'b0;
      clear = 1'b1; start = 1'b1; in_valid = 1'b1;
      tick;
      clear = 1'b0; start = 1'b0;
      for (int i = 0; i < FP + 2; i++) begin
         if (in_ready) bad_rdy = 1'b1;
         tick;
      end
      in_valid = 1'b0;
      checks++;
      if (bad_rdy) begin failures++; $display("FAIL clear_ready got=1 exp=0"); end
      wait_done(d0, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL clear_done got=0 exp=1"); end
      checks++;
      if (wa_q.size() - w0 !== FP) begin
         failures++; $display("FAIL clear_count got=%0d exp=%0d", wa_q.size() - w0, FP);
      end
      for (int i = 0; i < FP && w0 + i < wa_q.size(); i++) begin
         checks++;
         if (wa_q[w0+i] !== AW'(i) || wd_q[w0+i] !== 32'hDEAD) begin
            failures++; $display("FAIL clear_write%0d got addr=%0d data=%h exp addr=%0d data=0000dead",
                                 i, wa_q[w0+i], wd_q[w0+i], i);
         end
      end
   endtask
`endif

   initial begin
      test_reset;
      test_full_frame;
      test_backpressure;
      test_start_mid_frame;
      test_reset_mid_frame;
`ifdef FRAME_WRITER_CLEAR_EN
      test_clear;
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
